// File: rtl/mm2s_result_stream.sv
// mm2s_result_stream: buffers result row-vectors from the systolic array in a
// vector FIFO and serializes them onto a 32-bit AXI-Stream master. The last
// word of every matrix carries tlast, and done_read pulses once the matrix has
// left. Optional feature macro: MM2S_STALL_CNT_EN adds the stall_cycles output.
module mm2s_result_stream #(
  parameter int D_W_ACC      = 32,
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N2*D_W_ACC-1:0]   data_in,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [MATRIXSIZE_W-1:0] M1xM3dN2,
  output logic [31:0]             m_axis_mm2s_tdata,
  output logic [3:0]              m_axis_mm2s_tkeep,
  output logic                    m_axis_mm2s_tlast,
  output logic                    m_axis_mm2s_tvalid,
  input  logic                    m_axis_mm2s_tready,
  output logic                    done_read
`ifdef MM2S_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int VEC_W = N2 * D_W_ACC;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int IDX_W = (N2 > 1) ? $clog2(N2) : 1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N2 - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [VEC_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]           wrPtr_q, rdPtr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    readyIn_q;

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        wordIdx_q, wordIdx_d;
  logic [MATRIXSIZE_W-1:0] vecCnt_q, vecCnt_d;
  logic [MATRIXSIZE_W-1:0] size_q, size_d;
  logic [MATRIXSIZE_W-1:0] curSize;
  logic [VEC_W-1:0]        vec_q, vec_d;
  logic                    doneRead_q;

  logic                    push, pop, fifoEmpty, accept;
  logic                    firstWord, lastWord, lastVec;
  logic [D_W_ACC-1:0]      elem;

  assign push      = valid_in && readyIn_q;
  assign fifoEmpty = (count_q == '0);
  assign accept    = m_axis_mm2s_tvalid && m_axis_mm2s_tready;

  // The size input is only trusted until the first word of a matrix is taken;
  // after that the latched copy decides where tlast falls. A size of zero wraps
  // naturally to 2^MATRIXSIZE_W vectors through the modular subtraction.
  assign firstWord = (vecCnt_q == '0) && (wordIdx_q == '0);
  assign lastWord  = (wordIdx_q == LAST_IDX);
  assign curSize   = firstWord ? M1xM3dN2 : size_q;
  assign lastVec   = (vecCnt_q == (curSize - MATRIXSIZE_W'(1)));

  assign ready_in           = readyIn_q;
  assign m_axis_mm2s_tvalid = (state_q == ST_SEND);
  assign m_axis_mm2s_tlast  = (state_q == ST_SEND) && lastWord && lastVec;
  assign m_axis_mm2s_tkeep  = 4'hF;
  assign done_read          = doneRead_q;

  // Vector storage is written on every accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= data_in;
  end

  // Occupancy after this cycle's push/pop, used to register ready_in.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      readyIn_q <= 1'b1;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q   <= count_d;
      readyIn_q <= (count_d != DEPTH_C);
    end
  end

  // Serializer: load a vector, walk its words, reload without a bubble.
  always_comb begin
    state_d   = state_q;
    wordIdx_d = wordIdx_q;
    vecCnt_d  = vecCnt_q;
    size_d    = size_q;
    vec_d     = vec_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          pop       = 1'b1;
          vec_d     = mem[rdPtr_q];
          wordIdx_d = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (firstWord) size_d = M1xM3dN2;
          if (lastWord) begin
            wordIdx_d = '0;
            vecCnt_d  = lastVec ? '0 : vecCnt_q + MATRIXSIZE_W'(1);
            if (!fifoEmpty) begin
              pop   = 1'b1;
              vec_d = mem[rdPtr_q];
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            wordIdx_d = wordIdx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Serializer state; done_read follows the accepted tlast word by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wordIdx_q  <= '0;
      vecCnt_q   <= '0;
      size_q     <= '0;
      vec_q      <= '0;
      doneRead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      vecCnt_q   <= vecCnt_d;
      size_q     <= size_d;
      vec_q      <= vec_d;
      doneRead_q <= accept && m_axis_mm2s_tlast;
    end
  end

  // Pick the element currently being presented from the held vector.
  always_comb begin
    elem = vec_q[D_W_ACC-1:0];
    for (int k = 0; k < N2; k++) begin
      if (wordIdx_q == IDX_W'(k)) elem = vec_q[k*D_W_ACC +: D_W_ACC];
    end
  end

  generate
    if (D_W_ACC < 32) begin : gSext
      assign m_axis_mm2s_tdata = {{(32-D_W_ACC){elem[D_W_ACC-1]}}, elem};
    end else begin : gTrunc
      assign m_axis_mm2s_tdata = elem[31:0];
    end
  endgenerate

`ifdef MM2S_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stallNow;

  assign stallNow     = m_axis_mm2s_tvalid && !m_axis_mm2s_tready;
  assign stall_cycles = stall_q;

  // Saturating stall count, restarted at every matrix boundary.
  always_ff @(posedge clk) begin
    if (rst)                                         stall_q <= '0;
    else if (doneRead_q)                             stall_q <= {31'd0, stallNow};
    else if (stallNow && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mm2s_result_stream.sv
// Testbench for mm2s_result_stream: pushes directed and random result vectors
// and compares every output word, tlast and done_read against a queue model.
`timescale 1ns/1ps
module tb_mm2s_result_stream;

  localparam int D_W_ACC = 16;
  localparam int N2      = 4;
  localparam int MSW     = 4;
  localparam int DEPTH   = 16;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N2*D_W_ACC-1:0] dataIn;
  logic              validIn;
  logic              readyIn;
  logic [MSW-1:0]    sizeIn;
  logic [31:0]       tdata;
  logic [3:0]        tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic              doneRead;
`ifdef MM2S_STALL_CNT_EN
  logic [31:0]       stallCycles;
  logic [31:0]       stallAtLast;
  logic [31:0]       stallAfterDone;
  bit                captureNext;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cycleCnt = 0;
  int    hsCount = 0;
  int    lastCount = 0;
  int    doneCount = 0;
  int    pushCount = 0;
  int    lastHsCyc = 0;
  bit    monEn = 0;
  bit    doneExpected = 0;
  bit    prevStall = 0;
  logic [31:0] prevData = '0;
  bit    prevLast = 0;
  int    readyMode = 1;
  int    stallsLeft = 0;
  int    modelSizeVec = 1;
  int    modelVecIdx = 0;
  word_t expWords[$];
  logic [N2*D_W_ACC-1:0] pend[$];

  mm2s_result_stream #(
    .D_W_ACC(D_W_ACC), .N2(N2), .MATRIXSIZE_W(MSW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(dataIn),
    .valid_in(validIn),
    .ready_in(readyIn),
    .M1xM3dN2(sizeIn),
    .m_axis_mm2s_tdata(tdata),
    .m_axis_mm2s_tkeep(tkeep),
    .m_axis_mm2s_tlast(tlast),
    .m_axis_mm2s_tvalid(tvalid),
    .m_axis_mm2s_tready(tready),
    .done_read(doneRead)
`ifdef MM2S_STALL_CNT_EN
    ,
    .stall_cycles(stallCycles)
`endif
  );

  always #5 clk = ~clk;

  // Hard stop if the run somehow stops making progress.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N2*D_W_ACC-1:0] packVec(input logic [15:0] e0, input logic [15:0] e1,
                                                    input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [N2*D_W_ACC-1:0] randVec();
    return packVec(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endfunction

  task automatic setSize(input int n);
    sizeIn       = MSW'(n);
    modelSizeVec = (n == 0) ? (1 << MSW) : n;
  endtask

  // Reference model: every pushed vector becomes N2 signed 32-bit words; the
  // final element of the matrix's last vector is the tlast word.
  task automatic modelPush(input logic [N2*D_W_ACC-1:0] v);
    word_t w;
    for (int k = 0; k < N2; k++) begin
      w.data = 32'(int'($signed(v[k*D_W_ACC +: D_W_ACC])));
      w.last = (modelVecIdx == modelSizeVec - 1) && (k == N2 - 1);
      expWords.push_back(w);
    end
    modelVecIdx = (modelVecIdx + 1) % modelSizeVec;
  endtask

  task automatic checkOutput();
    word_t w;
    checkEq("done_read", 32'(doneRead), 32'(doneExpected));
    if (doneRead) doneCount++;
    if (prevStall) begin
      checkEq("hold_tvalid", 32'(tvalid), 32'd1);
      checkEq("hold_tdata", tdata, prevData);
      checkEq("hold_tlast", 32'(tlast), 32'(prevLast));
    end
    if (tvalid && tready) begin
      hsCount++;
      lastHsCyc = cycleCnt;
      if (tlast) lastCount++;
      checks++;
      assert (expWords.size() != 0) else begin
        errors++;
        $error("[TB] FAIL extra_word: observed %h expected no word", tdata);
      end
      if (expWords.size() != 0) begin
        w = expWords.pop_front();
        checkEq("tdata", tdata, w.data);
        checkEq("tlast", 32'(tlast), 32'(w.last));
        checkEq("tkeep", 32'(tkeep), 32'hF);
      end
    end
`ifdef MM2S_STALL_CNT_EN
    if (captureNext) begin
      stallAfterDone = stallCycles;
      captureNext    = 0;
    end
    if (doneRead) captureNext = 1;
    if (tvalid && tready && tlast) stallAtLast = stallCycles;
`endif
    doneExpected = tvalid && tready && tlast;
    prevStall    = tvalid && !tready;
    prevData     = tdata;
    prevLast     = tlast;
  endtask

  // One clock cycle: drive tready and the next pending vector, observe at the
  // falling edge, return 1 ns after the rising edge.
  task automatic applyStimulus();
    case (readyMode)
      0: tready = 1'b0;
      1: tready = 1'b1;
      2: tready = 1'($urandom_range(0, 1));
      default: begin
        if (stallsLeft > 0 && tvalid) begin
          tready = 1'b0;
          stallsLeft--;
        end else begin
          tready = 1'b1;
        end
      end
    endcase
    if (pend.size() > 0) begin
      validIn = 1'b1;
      dataIn  = pend[0];
    end else begin
      validIn = 1'b0;
    end
    @(negedge clk);
    if (validIn && readyIn) begin
      modelPush(pend.pop_front());
      pushCount++;
    end
    if (monEn) checkOutput();
    @(posedge clk);
    cycleCnt++;
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pend.size() > 0 || expWords.size() > 0 || tvalid) && n < 3000) begin
      applyStimulus();
      n++;
    end
    checks++;
    assert (n < 3000) else begin
      errors++;
      $error("[TB] FAIL %s_timeout: observed %0d cycles expected < 3000", tag, n);
    end
    repeat (3) applyStimulus();
  endtask

  task automatic checkResetValues(input string tag);
    checkEq({tag, "_ready_in"}, 32'(readyIn), 32'd1);
    checkEq({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    checkEq({tag, "_tlast"}, 32'(tlast), 32'd0);
    checkEq({tag, "_tdata"}, tdata, 32'd0);
    checkEq({tag, "_tkeep"}, 32'(tkeep), 32'hF);
    checkEq({tag, "_done"}, 32'(doneRead), 32'd0);
  endtask

  initial begin
    int hsBase, doneBase, lastBase, pushBase, firstCyc, n;

    rst     = 1'b1;
    tready  = 1'b1;
    validIn = 1'b0;
    dataIn  = '0;
    sizeIn  = '0;
`ifdef MM2S_STALL_CNT_EN
    captureNext    = 0;
    stallAtLast    = '0;
    stallAfterDone = '1;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues("reset");
    monEn = 1;

    // Basic stream: two vectors, first tvalid two cycles after the push.
    $display("[TB] basic stream");
    setSize(2);
    readyMode = 1;
    hsBase = hsCount; doneBase = doneCount; lastBase = lastCount;
    pend.push_back(packVec(16'd1, 16'd2, 16'd3, 16'd4));
    applyStimulus();
    checkEq("latency_t1_tvalid", 32'(tvalid), 32'd0);
    pend.push_back(packVec(16'd5, 16'd6, 16'd7, 16'd8));
    applyStimulus();
    checkEq("latency_t2_tvalid", 32'(tvalid), 32'd1);
    checkEq("latency_t2_tdata", tdata, 32'd1);
    firstCyc = cycleCnt;
    drain("basic");
    checkEq("basic_words", 32'(hsCount - hsBase), 32'd8);
    checkEq("basic_no_bubble", 32'(lastHsCyc - firstCyc), 32'd7);
    checkEq("basic_tlast_count", 32'(lastCount - lastBase), 32'd1);
    checkEq("basic_done_count", 32'(doneCount - doneBase), 32'd1);

    // Backpressure: the serializer holds one vector, so DEPTH+1 get in.
    $display("[TB] backpressure");
    setSize(5);
    readyMode = 0;
    hsBase = hsCount; doneBase = doneCount; lastBase = lastCount; pushBase = pushCount;
    for (int i = 0; i < 20; i++) pend.push_back(randVec());
    repeat (40) applyStimulus();
    checkEq("bp_accepted", 32'(pushCount - pushBase), 32'(DEPTH + 1));
    checkEq("bp_ready_low", 32'(readyIn), 32'd0);
    checkEq("bp_tvalid_held", 32'(tvalid), 32'd1);
    readyMode = 1;
    drain("bp");
    checkEq("bp_words", 32'(hsCount - hsBase), 32'd80);
    checkEq("bp_tlast_count", 32'(lastCount - lastBase), 32'd4);
    checkEq("bp_done_count", 32'(doneCount - doneBase), 32'd4);

    // Random tready over three back-to-back matrices.
    $display("[TB] random tready");
    setSize(5);
    readyMode = 2;
    hsBase = hsCount; doneBase = doneCount; lastBase = lastCount;
    for (int i = 0; i < 15; i++) pend.push_back(randVec());
    drain("rand");
    readyMode = 1;
    checkEq("rand_words", 32'(hsCount - hsBase), 32'd60);
    checkEq("rand_tlast_count", 32'(lastCount - lastBase), 32'd3);
    checkEq("rand_done_count", 32'(doneCount - doneBase), 32'd3);

    // Reset in the middle of a matrix, then a fresh one-vector matrix.
    $display("[TB] reset mid-matrix");
    setSize(4);
    readyMode = 1;
    hsBase = hsCount;
    for (int i = 0; i < 4; i++) pend.push_back(randVec());
    n = 0;
    while ((hsCount - hsBase) < 6 && n < 200) begin
      applyStimulus();
      n++;
    end
    checkEq("midrst_words_before", 32'(hsCount - hsBase), 32'd6);
    monEn   = 0;
    rst     = 1'b1;
    validIn = 1'b0;
    pend.delete();
    @(posedge clk);
    cycleCnt++;
    #1;
    rst = 1'b0;
    expWords.delete();
    modelVecIdx  = 0;
    doneExpected = 0;
    prevStall    = 0;
    checkResetValues("midrst");
    monEn = 1;
    setSize(1);
    hsBase = hsCount; doneBase = doneCount; lastBase = lastCount;
    pend.push_back(packVec(16'hFF80, 16'h7FFF, 16'h8000, 16'h0001));
    applyStimulus();
    applyStimulus();
    checkEq("sext_tdata", tdata, 32'hFFFF_FF80);
    checkEq("sext_tkeep", 32'(tkeep), 32'hF);
    drain("fresh");
    checkEq("fresh_words", 32'(hsCount - hsBase), 32'd4);
    checkEq("fresh_tlast_count", 32'(lastCount - lastBase), 32'd1);
    checkEq("fresh_done_count", 32'(doneCount - doneBase), 32'd1);

    // Size 0 means 2^MSW vectors; a size change mid-matrix must be ignored.
    $display("[TB] size zero");
    setSize(0);
    readyMode  = 3;
    stallsLeft = 7;
    hsBase = hsCount; doneBase = doneCount; lastBase = lastCount;
`ifdef MM2S_STALL_CNT_EN
    captureNext    = 0;
    stallAtLast    = '0;
    stallAfterDone = '1;
`endif
    for (int i = 0; i < 16; i++) pend.push_back(randVec());
    n = 0;
    while ((hsCount - hsBase) < 2 && n < 200) begin
      applyStimulus();
      n++;
    end
    sizeIn = MSW'(3);
    drain("size0");
    checkEq("size0_words", 32'(hsCount - hsBase), 32'd64);
    checkEq("size0_tlast_count", 32'(lastCount - lastBase), 32'd1);
    checkEq("size0_done_count", 32'(doneCount - doneBase), 32'd1);
`ifdef MM2S_STALL_CNT_EN
    checkEq("stall_before_done", stallAtLast, 32'd7);
    checkEq("stall_after_done", stallAfterDone, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
